// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory arbiter
package mem_arb_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic P_FETCH = 1'b0;
  localparam logic P_LSU = 1'b1;
  typedef enum logic {IDLE, SPLIT} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement of store data and extraction/extension of load data
module mem_lane_align import mem_arb_pkg::*; (
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic        uns,
  output logic [7:0]  mask,
  output logic [63:0] wide,
  output logic [31:0] rdata
);
  logic [3:0] base;
  logic [63:0] sh;
  logic [31:0] r;
  assign base = size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : 4'b1111;
  assign mask = {4'b0000, base} << off;
  assign wide = {32'b0, wdata} << {off, 3'b000};
  assign sh = {hi, lo} >> {off, 3'b000};
  assign r = sh[31:0];
  assign rdata = size == SZ_B ? {{24{~uns & r[7]}}, r[7:0]} :
                 size == SZ_H ? {{16{~uns & r[15]}}, r[15:0]} : r;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/load-store arbiter with misaligned split and extended responses
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int ADDR_S = 512,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp0_err,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic              i_req1_we,
  input  logic [1:0]        i_req1_size,
  input  logic              i_req1_unsigned,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic              o_rsp1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam logic [ADDR_W-2:0] LIM = (ADDR_W-1)'(ADDR_S);
  state_t state;
  logic last, lo_err, g0, g1, first, hi_ph, sz_bad, acc1, f_oor, n_oor, h_oor, cur_oor, unused_ok;
  logic [ADDR_W-2:0] fi, n, nh;
  logic [31:0] lo_q, rd1, ext;
  logic [7:0] mask;
  logic [63:0] wide;
  logic [3:0] cur_mask;
  assign unused_ok = &{1'b0, i_req0_addr[1:0]};
  assign fi = {1'b0, i_req0_addr[ADDR_W-1:2]};
  assign n = {1'b0, i_req1_addr[ADDR_W-1:2]};
  assign nh = n + 1'b1;
  assign f_oor = fi >= LIM;
  assign n_oor = n >= LIM;
  assign h_oor = nh >= LIM;
  assign sz_bad = i_req1_size == 2'b11;
  assign hi_ph = state == SPLIT;
  assign g0 = !i_reset && !hi_ph && i_req0_valid && (!i_req1_valid || last == P_LSU);
  assign g1 = !i_reset && (hi_ph || (i_req1_valid && (!i_req0_valid || last == P_FETCH)));
  assign first = g1 && !hi_ph && !sz_bad && |mask[7:4];
  assign o_req0_ready = g0;
  assign o_req1_ready = g1 && !first;
  assign cur_oor = hi_ph ? h_oor : n_oor;
  assign cur_mask = hi_ph ? mask[7:4] : mask[3:0];
  assign acc1 = g1 && !sz_bad && !cur_oor;
  assign rd1 = acc1 ? i_mem_rdata : '0;
  assign o_mem_addr = g0 ? {1'b0, fi} : (g1 && !sz_bad) ? {1'b0, hi_ph ? nh : n} : '0;
  assign o_mem_bmask = g0 ? (f_oor ? 4'h0 : 4'hf) : acc1 ? cur_mask : 4'h0;
  assign o_mem_wren = acc1 && i_req1_we;
  assign o_mem_wdata = acc1 ? (hi_ph ? wide[63:32] : wide[31:0]) : '0;
  mem_lane_align u_align (
    .off(i_req1_addr[1:0]),
    .size(i_req1_size),
    .wdata(i_req1_wdata),
    .hi(hi_ph ? rd1 : 32'b0),
    .lo(hi_ph ? lo_q : rd1),
    .uns(i_req1_unsigned),
    .mask(mask),
    .wide(wide),
    .rdata(ext)
  );
  // arbitration state, split capture and registered responses
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      last <= P_LSU;
      lo_q <= '0;
      lo_err <= 1'b0;
      o_rsp0_valid <= 1'b0;
      o_rsp0_data <= '0;
      o_rsp0_err <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp1_data <= '0;
      o_rsp1_err <= 1'b0;
    end else begin
      state <= first ? SPLIT : IDLE;
      if (first) begin
        lo_q <= rd1;
        lo_err <= n_oor;
      end
      if (g0) last <= P_FETCH;
      else if (o_req1_ready) last <= P_LSU;
      o_rsp0_valid <= g0;
      o_rsp0_data <= (g0 && !f_oor) ? i_mem_rdata : '0;
      o_rsp0_err <= g0 && f_oor;
      o_rsp1_valid <= o_req1_ready;
      o_rsp1_data <= (o_req1_ready && !i_req1_we && !sz_bad) ? ext : '0;
      o_rsp1_err <= o_req1_ready && (sz_bad || cur_oor || (hi_ph && lo_err));
    end
endmodule
